// File: rtl/voice_scheduler_pkg.sv
// voice_scheduler_pkg
// Shared definitions for the voice scheduler slice. It holds the default
// widths, the scheduler FSM state type and the note-index to phase-step
// scale table.
package voice_scheduler_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_POS_W      = 13;
    localparam int DEF_TIMEOUT    = 255;
    localparam int SAMPLE_W       = 16;
    localparam int KEY_W          = 4;
    localparam int SCALE_W        = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_OUTPUT
    } state_e;

    // Phase step per note index, one semitone apart over 13 notes. Indices
    // 13..15 return 0, so the voice position is held.
    function automatic logic [SCALE_W-1:0] scale_of(input logic [KEY_W-1:0] idx);
        logic [SCALE_W-1:0] s;
        case (idx)
            4'd0:    s = 7'd37;
            4'd1:    s = 7'd39;
            4'd2:    s = 7'd41;
            4'd3:    s = 7'd44;
            4'd4:    s = 7'd46;
            4'd5:    s = 7'd49;
            4'd6:    s = 7'd52;
            4'd7:    s = 7'd55;
            4'd8:    s = 7'd58;
            4'd9:    s = 7'd62;
            4'd10:   s = 7'd66;
            4'd11:   s = 7'd69;
            4'd12:   s = 7'd74;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if
// Wavetable memory read bus.
//   mem_addr : {wave bank, voice phase} read address (scheduler drives)
//   mem_rd   : read request level, held until the read completes (scheduler drives)
//   mem_done : one-cycle pulse, mem_dout valid (memory drives)
//   mem_dout : signed sample (memory drives)
interface voice_scheduler_if
    import voice_scheduler_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
);
    logic [POS_W+1:0]           mem_addr;
    logic                       mem_rd;
    logic                       mem_done;
    logic signed [SAMPLE_W-1:0] mem_dout;

    modport master (output mem_addr, output mem_rd, input mem_done, input mem_dout);
    modport slave  (input mem_addr, input mem_rd, output mem_done, output mem_dout);
endinterface

// File: rtl/voice_phase_bank.sv
// voice_phase_bank
// Per-voice phase accumulator storage. The voice selected by sel_i is
// cleared (clr_i) or advanced by its scale step (adv_i). Its current
// position is presented on pos_o.
//   clk_50, daclrck : clock, async active-high reset (all positions to 0)
//   sel_i           : voice index
//   adv_i, clr_i    : advance / clear selected voice (clear wins)
//   key_val_i       : note index of the selected voice
//   pos_o           : current position of the selected voice
module voice_phase_bank
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int POS_W      = DEF_POS_W,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic             clk_50,
    input  logic             daclrck,
    input  logic [VW-1:0]    sel_i,
    input  logic             adv_i,
    input  logic             clr_i,
    input  logic [KEY_W-1:0] key_val_i,
    output logic [POS_W-1:0] pos_o
);
    logic [POS_W-1:0] pos_q [NUM_VOICES];
    logic [POS_W-1:0] pos_d [NUM_VOICES];

    // The addition wraps modulo 2^POS_W by truncation.
    always_comb begin
        pos_d = pos_q;
        if (clr_i) begin
            pos_d[sel_i] = '0;
        end else if (adv_i) begin
            pos_d[sel_i] = pos_q[sel_i] + POS_W'(scale_of(key_val_i));
        end
    end

    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q[sel_i];

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler
// Time-multiplexed wavetable voice mixer. On each sample_tick it walks the
// voices in turn. For each keyed voice it reads one sample from wavetable
// memory, sums the samples, and emits the average on mix_out with a
// one-cycle mix_valid pulse.
//   clk_50, daclrck   : clock, async active-high reset
//   sample_tick       : frame start pulse
//   wave_select       : wavetable bank (upper address bits)
//   key_on, key_val   : per-voice gate and 4-bit note index
//   mem               : wavetable read bus (master side)
//   mix_out/mix_valid : mixed sample and its update strobe
//   busy              : frame in progress
//   overrun, timeout  : sticky error flags
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int POS_W      = DEF_POS_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                        clk_50,
    input  logic                        daclrck,
    input  logic                        sample_tick,
    input  logic [1:0]                  wave_select,
    input  logic [NUM_VOICES-1:0]       key_on,
    input  logic [KEY_W*NUM_VOICES-1:0] key_val,
    voice_scheduler_if.master           mem,
    output logic signed [SAMPLE_W-1:0]  mix_out,
    output logic                        mix_valid,
    output logic                        busy,
    output logic                        overrun,
    output logic                        timeout
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                      state_q, state_d;
    logic [VW-1:0]               v_q, v_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [SAMPLE_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]       kon_q, kon_d;
    logic [KEY_W*NUM_VOICES-1:0] kval_q, kval_d;
    logic [1:0]                  ws_q, ws_d;
    logic                        rd_q, rd_d;
    logic [POS_W+1:0]            addr_q, addr_d;
    logic signed [SAMPLE_W-1:0]  mix_q, mix_d;
    logic                        mv_q, mv_d;
    logic                        ovr_q, ovr_d;
    logic                        tmo_q, tmo_d;

    logic                        adv_pos, clr_pos;
    logic [POS_W-1:0]            pos;
    logic [KEY_W-1:0]            cur_kv;
    logic                        last_v;

    assign cur_kv = kval_q[{v_q, 2'b00} +: KEY_W];
    assign last_v = (v_q == VW'(NUM_VOICES - 1));

    voice_phase_bank #(
        .NUM_VOICES (NUM_VOICES),
        .POS_W      (POS_W)
    ) u_phase (
        .clk_50    (clk_50),
        .daclrck   (daclrck),
        .sel_i     (v_q),
        .adv_i     (adv_pos),
        .clr_i     (clr_pos),
        .key_val_i (cur_kv),
        .pos_o     (pos)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        acc_d   = acc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        kon_d   = kon_q;
        kval_d  = kval_q;
        ws_d    = ws_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        mix_d   = mix_q;
        mv_d    = 1'b0;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        adv_pos = 1'b0;
        clr_pos = 1'b0;

        // A tick that lands on any busy cycle, including OUTPUT, is dropped.
        if (sample_tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    kon_d   = key_on;
                    kval_d  = key_val;
                    ws_d    = wave_select;
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (kon_q[v_q]) begin
                    // The request is registered here so that it is already visible during ISSUE.
                    rd_d    = 1'b1;
                    addr_d  = {ws_q, pos};
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    clr_pos = 1'b1;
                    if (last_v) state_d = S_OUTPUT;
                    else        v_d = v_q + 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_done) begin
                    data_d  = mem.mem_dout;
                    rd_d    = 1'b0;
                    state_d = S_ACCUM;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Give up on this read: the voice contributes silence but keeps its phase moving.
                    data_d  = '0;
                    rd_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_ACCUM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACCUM: begin
                acc_d   = acc_q + {{VW{data_q[SAMPLE_W-1]}}, data_q};
                adv_pos = 1'b1;
                if (last_v) begin
                    state_d = S_OUTPUT;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_OUTPUT: begin
                mix_d   = SAMPLE_W'(acc_q >>> VW);
                mv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge daclrck) begin
        if (daclrck) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            kon_q   <= '0;
            kval_q  <= '0;
            ws_q    <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            mix_q   <= '0;
            mv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            kon_q   <= kon_d;
            kval_q  <= kval_d;
            ws_q    <= ws_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            mix_q   <= mix_d;
            mv_q    <= mv_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem.mem_rd   = rd_q;
    assign mem.mem_addr = addr_q;
    assign mix_out      = mix_q;
    assign mix_valid    = mv_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = ovr_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler
// Directed scoreboard bench for voice_scheduler (4 voices, 13-bit phase).
// The stimulus pushes the expected mix samples and read addresses into queues.
// A negedge monitor pops and compares them whenever the DUT presents them.
module tb_voice_scheduler;

    logic        clk_50 = 1'b0;
    logic        daclrck = 1'b0;
    logic        sample_tick = 1'b0;
    logic [1:0]  wave_select = 2'd0;
    logic [3:0]  key_on = 4'd0;
    logic [15:0] key_val = 16'd0;
    logic [15:0] mix_out;
    logic        mix_valid, busy, overrun, timeout;

    voice_scheduler_if #(.POS_W(13)) mif ();

    voice_scheduler #(.NUM_VOICES(4), .POS_W(13), .TIMEOUT(255)) dut (
        .clk_50      (clk_50),
        .daclrck     (daclrck),
        .sample_tick (sample_tick),
        .wave_select (wave_select),
        .key_on      (key_on),
        .key_val     (key_val),
        .mem         (mif),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    initial forever #10 clk_50 = ~clk_50;

    int          errors = 0;
    int          checks = 0;
    int          mv_cnt = 0;
    int          rd_cnt = 0;
    logic        addr_chk = 1'b0;
    int          mem_lat = 2;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] exp_mix[$];
    logic [14:0] exp_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wavetable memory: answers a read mem_lat cycles after mem_rd rises; mem_lat=0 never answers.
    initial begin : mem_model
        int  wcnt;
        bit  served;
        wcnt = 0;
        served = 0;
        mif.mem_done = 1'b0;
        mif.mem_dout = 16'sd0;
        forever begin
            @(posedge clk_50);
            #1;
            mif.mem_done = 1'b0;
            if (mif.mem_rd) begin
                if (!served) begin
                    wcnt++;
                    if (mem_lat > 0 && wcnt == mem_lat) begin
                        mif.mem_done = 1'b1;
                        mif.mem_dout = mem_data;
                        served = 1;
                    end
                end
            end else begin
                wcnt = 0;
                served = 0;
            end
        end
    end

    initial begin : monitor
        logic        rd_prev;
        logic [15:0] em;
        logic [14:0] ea;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk_50);
            if (mix_valid) begin
                mv_cnt++;
                if (exp_mix.size() == 0) begin
                    chk("mix_unexpected", {16'd0, mix_out}, 32'hFFFF_FFFF);
                end else begin
                    em = exp_mix.pop_front();
                    chk("mix_out", {16'd0, mix_out}, {16'd0, em});
                end
            end
            if (mif.mem_rd && !rd_prev) begin
                rd_cnt++;
                if (addr_chk) begin
                    if (exp_addr.size() == 0) begin
                        chk("addr_unexpected", {17'd0, mif.mem_addr}, 32'hFFFF_FFFF);
                    end else begin
                        ea = exp_addr.pop_front();
                        chk("mem_addr", {17'd0, mif.mem_addr}, {17'd0, ea});
                    end
                end
            end
            rd_prev = mif.mem_rd;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk_50);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_bound: busy still %0d after %0d cycles", busy, n);
        end
        @(posedge clk_50);
        #1;
    endtask

    task automatic tick(input logic [3:0] kon, input logic [15:0] kv, input logic [1:0] ws);
        @(posedge clk_50);
        #1;
        key_on = kon;
        key_val = kv;
        wave_select = ws;
        sample_tick = 1'b1;
        @(posedge clk_50);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic frame(input logic [3:0] kon, input logic [15:0] kv, input logic [1:0] ws);
        tick(kon, kv, ws);
        wait_idle();
    endtask

    initial begin : stim
        int lat, rd0, mv0;

        // Reset values, observed with no clock edge yet
        #2 daclrck = 1'b1;
        #3;
        chk("rst_mix_out", {16'd0, mix_out}, 32'd0);
        chk("rst_mix_valid", {31'd0, mix_valid}, 32'd0);
        chk("rst_mem_rd", {31'd0, mif.mem_rd}, 32'd0);
        chk("rst_mem_addr", {17'd0, mif.mem_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        repeat (2) @(posedge clk_50);
        #5 daclrck = 1'b0;

        // All voices off: latency 6 cycles from tick rise, silence, no reads
        exp_mix.push_back(16'h0000);
        rd0 = rd_cnt;
        tick(4'b0000, 16'h0000, 2'd0);
        lat = 1;
        while (!mix_valid && lat < 50) begin
            @(posedge clk_50);
            #1;
            lat++;
        end
        chk("latency_all_off", lat, 6);
        wait_idle();
        chk("no_reads_all_off", rd_cnt - rd0, 0);

        // Voice0 alone, note 0, sample 0x4000: mix 0x1000, phase 0,37,74,111
        mem_lat = 2;
        mem_data = 16'h4000;
        addr_chk = 1'b1;
        exp_addr.push_back(15'd0);
        exp_addr.push_back(15'd37);
        exp_addr.push_back(15'd74);
        exp_addr.push_back(15'd111);
        repeat (4) begin
            exp_mix.push_back(16'h1000);
            frame(4'b0001, 16'h0000, 2'd0);
        end
        addr_chk = 1'b0;

        // All voices at full scale, both signs, then clear every phase
        mem_data = 16'h7FFF;
        exp_mix.push_back(16'h7FFF);
        frame(4'b1111, 16'h0000, 2'd0);
        mem_data = 16'h8000;
        exp_mix.push_back(16'h8000);
        frame(4'b1111, 16'h0000, 2'd0);
        exp_mix.push_back(16'h0000);
        frame(4'b0000, 16'h0000, 2'd0);

        // Note 12 for 111 frames wraps to 22; note 15 holds; key off clears
        mem_data = 16'h0000;
        repeat (111) begin
            exp_mix.push_back(16'h0000);
            frame(4'b0001, 16'h000C, 2'd0);
        end
        addr_chk = 1'b1;
        exp_addr.push_back(15'd22);
        exp_addr.push_back(15'd22);
        exp_addr.push_back(15'd0);
        exp_mix.push_back(16'h0000);
        frame(4'b0001, 16'h000F, 2'd0);
        exp_mix.push_back(16'h0000);
        frame(4'b0001, 16'h000F, 2'd0);
        exp_mix.push_back(16'h0000);
        frame(4'b0000, 16'h000F, 2'd0);
        exp_mix.push_back(16'h0000);
        frame(4'b0001, 16'h0000, 2'd0);

        // Second tick during the read is dropped: overrun and one mix only
        chk("overrun_clear_before", {31'd0, overrun}, 32'd0);
        mem_lat = 5;
        mem_data = 16'h4000;
        exp_addr.push_back(15'd37);
        exp_mix.push_back(16'h1000);
        mv0 = mv_cnt;
        tick(4'b0001, 16'h0000, 2'd0);
        @(posedge clk_50);
        #1 sample_tick = 1'b1;
        @(posedge clk_50);
        #1 sample_tick = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk_50);
        #1;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("single_mix_valid", mv_cnt - mv0, 1);

        // Memory never answers: timeout, silent voice, phase still advances
        mem_lat = 0;
        exp_addr.push_back({2'd1, 13'd74});
        exp_mix.push_back(16'h0000);
        frame(4'b0001, 16'h0000, 2'd1);
        chk("timeout_set", {31'd0, timeout}, 32'd1);
        mem_lat = 2;
        exp_addr.push_back({2'd1, 13'd111});
        exp_mix.push_back(16'h1000);
        frame(4'b0001, 16'h0000, 2'd1);

        // Reset in the middle of a read: mem_rd drops with no clock edge
        mem_lat = 0;
        exp_addr.push_back(15'd148);
        tick(4'b0001, 16'h0000, 2'd0);
        repeat (4) @(posedge clk_50);
        #2;
        chk("rd_before_rst", {31'd0, mif.mem_rd}, 32'd1);
        daclrck = 1'b1;
        #1;
        chk("rd_async_clear", {31'd0, mif.mem_rd}, 32'd0);
        chk("mix_out_rst", {16'd0, mix_out}, 32'd0);
        chk("overrun_rst", {31'd0, overrun}, 32'd0);
        chk("timeout_rst", {31'd0, timeout}, 32'd0);
        chk("busy_rst", {31'd0, busy}, 32'd0);
        #4 daclrck = 1'b0;
        mem_lat = 2;
        exp_addr.push_back({2'd2, 13'd0});
        exp_mix.push_back(16'h1000);
        frame(4'b0001, 16'h0000, 2'd2);
        addr_chk = 1'b0;

        repeat (3) @(posedge clk_50);
        #1;
        chk("mix_queue_drained", exp_mix.size(), 0);
        chk("addr_queue_drained", exp_addr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of time-multiplexed voices (power of two, 2..8).
REQ-002 SHALL have parameter POS_W, default 13, phase accumulator width per voice.
REQ-003 SHALL have parameter TIMEOUT, default 255, max clk_50 cycles waited for mem_done.
REQ-004 clk_50  in  1  system clock, all logic rising-edge.
REQ-005 daclrck  in  1  reset, asynchronous, active-high.
REQ-006 sample_tick  in  1  one-cycle pulse per audio frame (~48.8 kHz), clk_50 domain.
REQ-007 wave_select  in  2  waveform bank, upper address bits.
REQ-008 key_on  in  NUM_VOICES  per-voice gate.
REQ-009 key_val  in  4*NUM_VOICES  per-voice note index, voice v at bits [4v+3:4v].
REQ-010 mem_addr  out  2+POS_W  read address {wave_select, pos[v]}.
REQ-011 mem_rd  out  1  read request, level.
REQ-012 mem_done  in  1  one-cycle pulse, mem_dout valid.
REQ-013 mem_dout  in  16  signed two's-complement sample.
REQ-014 mix_out  out  16  mixed signed sample.
REQ-015 mix_valid  out  1  one-cycle pulse, mix_out updated.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 overrun  out  1  sticky, sample_tick received while busy.
REQ-018 timeout  out  1  sticky, a read exceeded TIMEOUT.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, ISSUE, WAIT, ACCUM, OUTPUT.
REQ-020 IDLE + sample_tick SHALL snapshot key_on, key_val, and wave_select, clear the accumulator, set v=0, and go to SELECT.
REQ-021 SELECT, snapshot key_on[v]=0: pos[v] cleared to 0, contributes 0, advance voice (1 cycle).
REQ-022 SELECT, key_on[v]=1: go to ISSUE.
REQ-023 ISSUE SHALL drive mem_addr={wave_select_snap, pos[v]} and mem_rd=1, then go to WAIT.
REQ-024 mem_rd and mem_addr SHALL stay stable through WAIT until mem_done is sampled high; mem_rd deasserts the cycle after.
REQ-025 mem_done outside WAIT SHALL be ignored.
REQ-026 ACCUM SHALL add sign-extended mem_dout into a (16+log2 NUM_VOICES)-bit accumulator, no saturation needed.
REQ-027 ACCUM SHALL set pos[v] = (pos[v] + scale(key_val[v])) mod 2^POS_W.
REQ-028 scale table SHALL map index 0..12 to 37,39,41,44,46,49,52,55,58,62,66,69,74; indices 13..15 SHALL give scale 0 (position held).
REQ-029 After each voice, v increments; after voice NUM_VOICES-1, go to OUTPUT.
REQ-030 OUTPUT SHALL set mix_out = accumulator arithmetic-shifted right by log2(NUM_VOICES) and pulse mix_valid for one cycle.
REQ-031 OUTPUT SHALL return to IDLE; mix_out SHALL hold between frames.
REQ-032 sample_tick in any non-IDLE state SHALL be dropped and set overrun; coincident with the OUTPUT cycle counts as busy.
REQ-033 In WAIT, if TIMEOUT cycles elapse without mem_done: drop mem_rd, set timeout, contribute 0, still advance pos[v], continue.
REQ-034 key_on/key_val changes mid-frame SHALL take effect only at the next sample_tick.
REQ-035 Frame latency, all voices off: mix_valid SHALL pulse exactly NUM_VOICES+2 cycles after the sample_tick edge.

Reset
REQ-036 daclrck high SHALL immediately force state IDLE and clear mem_rd, mem_addr, mix_out, mix_valid, overrun, timeout, all pos[], and the accumulator, independent of clk_50.
REQ-037 Reset mid-read SHALL abandon the transaction; a later stray mem_done SHALL be ignored.

Structure
REQ-038 Shared package SHALL hold the FSM state enum, the 13-entry scale table, and the default widths.
REQ-039 One sub-module, voice_phase_bank (pos[] storage plus scale lookup/add), is natural; everything else is in voice_scheduler.

Verification
REQ-040 All key_on=0, tick: mix_valid once, NUM_VOICES+2 cycles later, mix_out=0, mem_rd never high.
REQ-041 Voice0 on, key_val=0, memory returns 16'h4000 after 2 cycles: mix_out=16'h1000; next frame mem_addr[12:0]=37; after 3 frames pos=111.
REQ-042 All 4 voices on, mem returns 16'h7FFF: mix_out=16'h7FFF; with 16'h8000: mix_out=16'h8000.
REQ-043 Voice0 key_val=12 for 111 frames: pos=(74*111) mod 8192=22; key_val=15: pos unchanged; key_on dropped: pos=0.
REQ-044 Second tick while in WAIT: overrun=1, single mix_valid; mem_done withheld 256 cycles: timeout=1, voice contributes 0, frame completes.
REQ-045 daclrck asserted during WAIT: mem_rd low without a clk_50 edge; after release, all pos=0, first frame starts from address {wave_select,13'd0}.
